// File: rtl/mtf_cpg_array.sv
// Bank of N_NEURONS MTF neurons (fast/slow/ultraslow state) time-multiplexed on one
// RD/CALC/WB datapath. Define MTF_SYN_EN to add unidirectional ring inhibition via w_syn.
module mtf_cpg_array #(
  parameter int N_NEURONS = 4,
  parameter int DW        = 16,
  parameter int FRAC      = 8,
  parameter int TS_SHIFT  = 4,
  parameter int TUS_SHIFT = 7
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      step,
  input  logic [2:0]                dt_shift,
  input  logic [8*N_NEURONS-1:0]    i_ext,
  input  logic signed [7:0]         afn,
  input  logic signed [7:0]         asp,
  input  logic signed [7:0]         asn,
  input  logic signed [7:0]         ausp,
  input  logic signed [7:0]         dfn,
  input  logic signed [7:0]         dsp,
  input  logic signed [7:0]         dsn,
  input  logic signed [7:0]         dusp,
  input  logic signed [7:0]         w_syn,
  output logic                      busy,
  output logic                      valid,
  output logic [DW*N_NEURONS-1:0]   voltage
);

  localparam int AW = DW + 10;
  localparam int KW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [KW-1:0]        K_LAST = KW'(N_NEURONS - 1);
  localparam logic signed [AW-1:0] ONE    = AW'(64'sd1 <<< FRAC);
  localparam logic signed [AW-1:0] V_MAX  = AW'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] V_MIN  = AW'(-(64'sd1 <<< (DW - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WB,
    S_DONE
  } state_t;

  function automatic logic signed [AW-1:0] ext8(input logic signed [7:0] x);
    return {{(AW-8){x[7]}}, x};
  endfunction

  function automatic logic signed [AW-1:0] ext_dw(input logic signed [DW-1:0] x);
    return {{(AW-DW){x[DW-1]}}, x};
  endfunction

  function automatic logic signed [AW-1:0] sat_one(input logic signed [AW-1:0] x);
    if (x > ONE)  return ONE;
    if (x < -ONE) return -ONE;
    return x;
  endfunction

  state_t               r_state;
  logic [KW-1:0]        r_k;

  logic signed [DW-1:0] r_v   [N_NEURONS];
  logic signed [DW-1:0] r_vs  [N_NEURONS];
  logic signed [DW-1:0] r_vus [N_NEURONS];

  logic signed [7:0]    r_iext [N_NEURONS];
  logic signed [7:0]    r_afn, r_asp, r_asn, r_ausp;
  logic signed [7:0]    r_dfn, r_dsp, r_dsn, r_dusp;
  logic [2:0]           r_dt;

  logic signed [DW-1:0] r_pv, r_pvs, r_pvus;
  logic signed [AW-1:0] r_dv;

  logic signed [AW-1:0] w_s_fn, w_s_sp, w_s_sn, w_s_usp;
  logic signed [AW-1:0] w_i_mtf, w_i_syn, w_dv;
  logic signed [AW-1:0] w_vsum, w_vsat;
  logic signed [DW:0]   w_dvs, w_dvus, w_dvs_sh, w_dvus_sh;
  logic signed [DW-1:0] w_v_new, w_vs_new, w_vus_new;

`ifdef MTF_SYN_EN
  logic signed [7:0]    r_wsyn;
  logic signed [DW-1:0] r_pvsyn;
  logic [KW-1:0]        w_pred;

  function automatic logic signed [AW-1:0] sat_pos(input logic signed [AW-1:0] x);
    if (x > ONE)       return ONE;
    if (x < $signed('0)) return '0;
    return x;
  endfunction

  assign w_pred  = (r_k == '0) ? K_LAST : r_k - 1'b1;
  assign w_i_syn = -(ext8(r_wsyn) * sat_pos(ext_dw(r_pvsyn)));
`else
  logic w_unused_syn;
  assign w_unused_syn = ^w_syn;
  assign w_i_syn      = '0;
`endif

  // CALC: offsets are integers, so they are lifted to the Q format before the subtraction.
  always_comb begin
    w_s_fn  = sat_one(ext_dw(r_pv)   - (ext8(r_dfn)  <<< FRAC));
    w_s_sp  = sat_one(ext_dw(r_pvs)  - (ext8(r_dsp)  <<< FRAC));
    w_s_sn  = sat_one(ext_dw(r_pvs)  - (ext8(r_dsn)  <<< FRAC));
    w_s_usp = sat_one(ext_dw(r_pvus) - (ext8(r_dusp) <<< FRAC));
    w_i_mtf = ext8(r_afn) * w_s_fn + ext8(r_asp) * w_s_sp
            + ext8(r_asn) * w_s_sn + ext8(r_ausp) * w_s_usp;
    w_dv    = w_i_syn - ext_dw(r_pv) - w_i_mtf + (ext8(r_iext[r_k]) <<< FRAC);
  end

  // WB: the voltage saturates instead of wrapping; the filters always track the old v.
  always_comb begin
    w_vsum = ext_dw(r_pv) + (r_dv >>> r_dt);
    if (w_vsum > V_MAX)      w_vsat = V_MAX;
    else if (w_vsum < V_MIN) w_vsat = V_MIN;
    else                     w_vsat = w_vsum;
    w_v_new   = w_vsat[DW-1:0];
    w_dvs     = {r_pv[DW-1], r_pv} - {r_pvs[DW-1], r_pvs};
    w_dvus    = {r_pv[DW-1], r_pv} - {r_pvus[DW-1], r_pvus};
    w_dvs_sh  = w_dvs >>> TS_SHIFT;
    w_dvus_sh = w_dvus >>> TUS_SHIFT;
    w_vs_new  = r_pvs + w_dvs_sh[DW-1:0];
    w_vus_new = r_pvus + w_dvus_sh[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      voltage <= '0;
      // NOTE: the neuron state is a handful of registers, not a RAM, so it is reset like any other flop.
      for (int j = 0; j < N_NEURONS; j++) begin
        r_v[j]    <= '0;
        r_vs[j]   <= '0;
        r_vus[j]  <= '0;
        r_iext[j] <= '0;
      end
      r_afn  <= '0;
      r_asp  <= '0;
      r_asn  <= '0;
      r_ausp <= '0;
      r_dfn  <= '0;
      r_dsp  <= '0;
      r_dsn  <= '0;
      r_dusp <= '0;
      r_dt   <= '0;
      r_pv   <= '0;
      r_pvs  <= '0;
      r_pvus <= '0;
      r_dv   <= '0;
`ifdef MTF_SYN_EN
      r_wsyn  <= '0;
      r_pvsyn <= '0;
`endif
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (step) begin
            for (int j = 0; j < N_NEURONS; j++) r_iext[j] <= i_ext[8*j +: 8];
            r_afn   <= afn;
            r_asp   <= asp;
            r_asn   <= asn;
            r_ausp  <= ausp;
            r_dfn   <= dfn;
            r_dsp   <= dsp;
            r_dsn   <= dsn;
            r_dusp  <= dusp;
            r_dt    <= dt_shift;
`ifdef MTF_SYN_EN
            r_wsyn  <= w_syn;
`endif
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_pv    <= r_v[r_k];
          r_pvs   <= r_vs[r_k];
          r_pvus  <= r_vus[r_k];
`ifdef MTF_SYN_EN
          r_pvsyn <= voltage[int'(w_pred)*DW +: DW];
`endif
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_dv    <= w_dv;
          r_state <= S_WB;
        end
        S_WB: begin
          r_v[r_k]   <= w_v_new;
          r_vs[r_k]  <= w_vs_new;
          r_vus[r_k] <= w_vus_new;
          if (r_k == K_LAST) begin
            // The last neuron's new v is not in r_v yet, so it is taken straight from the datapath.
            for (int j = 0; j < N_NEURONS; j++)
              voltage[j*DW +: DW] <= (j == N_NEURONS - 1) ? w_v_new : r_v[j];
            valid   <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= S_RD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mtf_cpg_array.sv
// Directed bench for mtf_cpg_array: reset, leak/drive, saturation, busy-ignore,
// bursting and ring coupling (expectation follows MTF_SYN_EN).
`timescale 1ns/1ps
module tb_mtf_cpg_array;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int LAT = 3 * N;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 step = 1'b0;
  logic [2:0]           dt_shift = '0;
  logic [8*N-1:0]       i_ext = '0;
  logic signed [7:0]    afn = '0, asp = '0, asn = '0, ausp = '0;
  logic signed [7:0]    dfn = '0, dsp = '0, dsn = '0, dusp = '0;
  logic signed [7:0]    w_syn = '0;
  logic                 busy, valid;
  logic [DW*N-1:0]      voltage;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mtf_cpg_array #(.N_NEURONS(N), .DW(DW), .FRAC(8), .TS_SHIFT(4), .TUS_SHIFT(7)) dut (
    .clk(clk), .reset(reset), .step(step), .dt_shift(dt_shift), .i_ext(i_ext),
    .afn(afn), .asp(asp), .asn(asn), .ausp(ausp),
    .dfn(dfn), .dsp(dsp), .dsn(dsn), .dusp(dusp),
    .w_syn(w_syn), .busy(busy), .valid(valid), .voltage(voltage)
  );

  function automatic logic signed [DW-1:0] lane(input int k);
    return voltage[k*DW +: DW];
  endfunction

  task automatic clear_inputs();
    dt_shift = '0; i_ext = '0; w_syn = '0;
    afn = '0; asp = '0; asn = '0; ausp = '0;
    dfn = '0; dsp = '0; dsn = '0; dusp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Issues one step from IDLE, returns edges from acceptance to valid, then returns to IDLE.
  task automatic run_step(output int lat);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    lat = 0;
    while (!valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (!valid) begin
      failures++;
      $display("FAIL step_timeout: valid not seen after %0d cycles (required within %0d)", lat, LAT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int lat;
    do_reset();
    clear_inputs();
    i_ext = 32'h0000_0001;
    run_step(lat);
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (voltage !== '0) begin
      failures++; $display("FAIL reset_voltage: got %h required 0", voltage);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid: got %b required 0", valid);
    end
    reset = 1'b1;
    run_step(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL reset_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (lane(0) !== 16'sd256) begin
      failures++; $display("FAIL reset_v0: got %0d required 256", lane(0));
    end
    checks++;
    if (dut.r_vs[0] !== 16'sd0) begin
      failures++; $display("FAIL reset_vs0: got %0d required 0", dut.r_vs[0]);
    end
  endtask

  task automatic test_leak_drive();
    int lat;
    do_reset();
    clear_inputs();
    i_ext = 32'h0000_0001;
    run_step(lat);
    checks++;
    if (lat !== LAT) begin
      failures++; $display("FAIL leak_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    if (voltage !== 64'h0000_0000_0000_0100) begin
      failures++; $display("FAIL leak_step1_voltage: got %h required 0000000000000100", voltage);
    end
    checks++;
    if (dut.r_vs[0] !== 16'sd0) begin
      failures++; $display("FAIL leak_step1_vs0: got %0d required 0", dut.r_vs[0]);
    end
    run_step(lat);
    checks++;
    if (voltage !== 64'h0000_0000_0000_0100) begin
      failures++; $display("FAIL leak_step2_voltage: got %h required 0000000000000100", voltage);
    end
    checks++;
    if (dut.r_vs[0] !== 16'sd16) begin
      failures++; $display("FAIL leak_step2_vs0: got %0d required 16", dut.r_vs[0]);
    end
    checks++;
    if (dut.r_vus[0] !== 16'sd2) begin
      failures++; $display("FAIL leak_step2_vus0: got %0d required 2", dut.r_vus[0]);
    end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    clear_inputs();
    afn = -8'sd128;
    i_ext = 32'h0000_007F;
    run_step(lat);
    checks++;
    if (voltage !== 64'h0000_0000_0000_7F00) begin
      failures++; $display("FAIL sat_step1_voltage: got %h required 0000000000007f00", voltage);
    end
    run_step(lat);
    checks++;
    if (voltage !== 64'h0000_0000_0000_7FFF) begin
      failures++; $display("FAIL sat_step2_voltage: got %h required 0000000000007fff", voltage);
    end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    do_reset();
    clear_inputs();
    i_ext = 32'h0000_0001;
    step = 1'b1;
    @(posedge clk);
    #1 step = 1'b0;
    i_ext = 32'h0000_0005;
    @(posedge clk);
    #1 step = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL busy_high: got %b required 1", busy);
    end
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 step = 1'b0;
      if (valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++; $display("FAIL busy_pulses: got %0d required 1", pulses);
    end
    checks++;
    if (lane(0) !== 16'sd256) begin
      failures++; $display("FAIL busy_v0: got %0d required 256", lane(0));
    end
    checks++;
    if (dut.r_vs[0] !== 16'sd0) begin
      failures++; $display("FAIL busy_vs0: got %0d required 0", dut.r_vs[0]);
    end
  endtask

  task automatic test_bursting();
    int lat, n_cross, n_rise, first_rise, last_rise;
    logic prev_neg, cur_neg;
    do_reset();
    clear_inputs();
    afn = -8'sd3; asp = 8'sd3; asn = -8'sd2; ausp = 8'sd2;
    dsn = -8'sd2; dusp = -8'sd2;
    dt_shift = 3'd3;
    i_ext = {4{8'hFE}};
    n_cross = 0; n_rise = 0; first_rise = -1; last_rise = -1;
    prev_neg = 1'b0;
    for (int s = 0; s < 2000; s++) begin
      run_step(lat);
      cur_neg = lane(0) < 0;
      if (cur_neg != prev_neg) begin
        n_cross++;
        if (!cur_neg) begin
          n_rise++;
          if (first_rise < 0) first_rise = s;
          last_rise = s;
        end
      end
      prev_neg = cur_neg;
    end
    checks++;
    if (n_cross < 4) begin
      failures++; $display("FAIL burst_crossings: got %0d required >= 4", n_cross);
    end
    checks++;
    if (n_rise < 2 || (last_rise - first_rise) <= 16 * (n_rise - 1)) begin
      failures++;
      $display("FAIL burst_period: rises=%0d span=%0d steps, required mean period > 16",
               n_rise, last_rise - first_rise);
    end
  endtask

  task automatic test_coupling();
    int lat;
    logic [DW*N-1:0] exp_v;
    do_reset();
    clear_inputs();
    w_syn = 8'sd2;
    i_ext = 32'h0100_0000;
    run_step(lat);
    checks++;
    if (voltage !== 64'h0100_0000_0000_0000) begin
      failures++; $display("FAIL couple_preload: got %h required 0100000000000000", voltage);
    end
    i_ext = '0;
    run_step(lat);
`ifdef MTF_SYN_EN
    exp_v = 64'h0000_0000_0000_FE00;
`else
    exp_v = 64'h0000_0000_0000_0000;
`endif
    checks++;
    if (voltage !== exp_v) begin
      failures++; $display("FAIL couple_v0: got %h required %h", voltage, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_leak_drive();
    test_saturation();
    test_busy_ignore();
    test_bursting();
    test_coupling();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
